// File: rtl/read_and_d_loader.sv
// Sequence loader: accepts {symbol, D(i)} beats into a 256-entry table and
// serves a zero-latency read port gated by the number of entries loaded.
module read_and_d_loader #(
    parameter int unsigned CAP = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_sym,
    input  logic [7:0] in_d,
    input  logic       in_last,
    input  logic       ce,
    input  logic [7:0] addr,
    output logic [1:0] read_i,
    output logic [7:0] d_i,
    output logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    localparam logic [7:0] CapLen = 8'(CAP);

    state_e     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic       err_q, err_d;
    logic       wr_en;
    logic [9:0] rdata;
    logic [9:0] mem_q [256];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // Table contents survive reset and restart; len gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[len_q] <= {in_sym, in_d};
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        err_d    = err_q;
        in_ready = (state_q == StLoad) && (len_q < CapLen) && !start;
        wr_en    = in_valid && in_ready;
        if (start) begin
            state_d = StLoad;
            len_d   = 8'd0;
            err_d   = 1'b0;
        end else if (state_q == StLoad && in_valid) begin
            if (in_ready) begin
                len_d = len_q + 8'd1;
                if (in_last) begin
                    state_d = StDone;
                end
            end else begin
                // Table full and another beat offered: drop it and flag.
                err_d   = 1'b1;
                state_d = StDone;
            end
        end
    end

    always_comb begin
        rdata = 10'd0;
        if (ce && addr != 8'hff && addr < len_q) begin
            rdata = mem_q[addr];
        end
    end

    assign read_i = rdata[9:8];
    assign d_i    = rdata[7:0];
    assign len    = len_q;
    assign busy   = (state_q == StLoad);
    assign done   = (state_q == StDone);
    assign err    = err_q;

endmodule
